// File: rtl/mem_stage.sv
// MINA2000 memory-access stage: data-bus handshake, load alignment/extension,
// store lane replication, stall generation and the MEM/WB pipeline register.

package types;
  typedef logic [31:0] u32_t;

  typedef enum logic [3:0] {
    MEM_OP_NONE = 4'd0,
    MEM_OP_LB   = 4'd1,
    MEM_OP_LBU  = 4'd2,
    MEM_OP_LH   = 4'd3,
    MEM_OP_LHU  = 4'd4,
    MEM_OP_LW   = 4'd5,
    MEM_OP_SB   = 4'd6,
    MEM_OP_SH   = 4'd7,
    MEM_OP_SW   = 4'd8
  } mem_op_t;

  typedef struct packed {
    logic [4:0] rd_addr;
    u32_t       rd_data;
    mem_op_t    mem_op;
    u32_t       mem_data;
  } mem_params_t;

  typedef struct packed {
    logic [4:0] rd_addr;
    u32_t       rd_data;
  } wb_params_t;
endpackage

module mem_stage
  import types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mem_params_t mem_params,
  input  logic        stall_in,
  output logic        mem_stall,
  output logic        misaligned,
  output wb_params_t  wb_params,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  // state  | meaning
  // S_IDLE | no access completed yet for the current EX/MEM contents
  // S_DONE | access finished while frozen; result parked in held_q
  typedef enum logic {S_IDLE, S_DONE} state_t;

  state_t     state_q, state_d;
  u32_t       held_q, held_d;
  wb_params_t wb_q, wb_d;

  u32_t       addr;
  logic       is_load, is_store, is_byte, is_half, is_word, sign_ext;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;
  u32_t       load_val;
  logic       acked, advance;

  assign addr = mem_params.rd_data;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    sign_ext = 1'b0;
    unique case (mem_params.mem_op)
      MEM_OP_LB:  begin is_load  = 1'b1; is_byte = 1'b1; sign_ext = 1'b1; end
      MEM_OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      MEM_OP_LH:  begin is_load  = 1'b1; is_half = 1'b1; sign_ext = 1'b1; end
      MEM_OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      MEM_OP_LW:  begin is_load  = 1'b1; is_word = 1'b1; end
      MEM_OP_SB:  begin is_store = 1'b1; is_byte = 1'b1; end
      MEM_OP_SH:  begin is_store = 1'b1; is_half = 1'b1; end
      MEM_OP_SW:  begin is_store = 1'b1; is_word = 1'b1; end
      default:    ;
    endcase
  end

  assign misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));

  assign bus_req   = (state_q == S_IDLE) && (is_load || is_store) && !misaligned && !rst;
  assign bus_we    = is_store;
  assign bus_addr  = {addr[31:2], 2'b00};
  assign mem_stall = bus_req && !bus_ack;

  always_comb begin
    bus_be    = 4'b0000;
    bus_wdata = mem_params.mem_data;
    if (is_byte) begin
      bus_be    = 4'b0001 << addr[1:0];
      bus_wdata = {4{mem_params.mem_data[7:0]}};
    end else if (is_half) begin
      bus_be    = 4'b0011 << addr[1:0];
      bus_wdata = {2{mem_params.mem_data[15:0]}};
    end else if (is_word) begin
      bus_be    = 4'b1111;
    end
  end

  always_comb begin
    byte_sel = bus_rdata[7:0];
    unique case (addr[1:0])
      2'd0: byte_sel = bus_rdata[7:0];
      2'd1: byte_sel = bus_rdata[15:8];
      2'd2: byte_sel = bus_rdata[23:16];
      2'd3: byte_sel = bus_rdata[31:24];
      default: ;
    endcase
    half_sel = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    // Stores complete with no register result.
    load_val = '0;
    if (is_load) begin
      if (is_byte)      load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      else if (is_half) load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
      else              load_val = bus_rdata;
    end
  end

  assign acked   = bus_req && bus_ack;
  assign advance = !mem_stall && !stall_in;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    wb_d    = wb_q;

    unique case (state_q)
      S_IDLE: if (acked && stall_in) begin
        state_d = S_DONE;
        held_d  = load_val;
      end
      S_DONE: if (!stall_in) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      wb_d.rd_addr = mem_params.rd_addr;
      if (state_q == S_DONE)        wb_d.rd_data = held_q;
      else if (acked)               wb_d.rd_data = load_val;
      else if (is_load || is_store) wb_d.rd_data = '0;
      else                          wb_d.rd_data = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      held_q  <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      wb_q    <= wb_d;
    end
  end

  assign wb_params = wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan cases plus randomized ops
// against a byte-lane arithmetic reference model.

module tb_mem_stage;
  import types::*;

  logic        clk = 1'b0;
  logic        rst;
  mem_params_t mem_params;
  logic        stall_in;
  logic        mem_stall;
  logic        misaligned;
  wb_params_t  wb_params;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  wb_params_t exp_wb;

  mem_stage dut (
    .clk(clk), .rst(rst), .mem_params(mem_params), .stall_in(stall_in),
    .mem_stall(mem_stall), .misaligned(misaligned), .wb_params(wb_params),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_req && bus_ack) xfer_cnt++;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1);
  end

  function automatic int op_size(input mem_op_t op);
    case (op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: return 1;
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return 2;
      MEM_OP_LW, MEM_OP_SW:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input mem_op_t op);
    return op == MEM_OP_SB || op == MEM_OP_SH || op == MEM_OP_SW;
  endfunction

  function automatic logic [31:0] ref_load(input mem_op_t op, input logic [31:0] addr,
                                           input logic [31:0] w);
    int unsigned off = addr % 4;
    logic [31:0] b = (w >> (8 * off)) % 256;
    logic [31:0] h = (w >> (8 * off)) % 65536;
    case (op)
      MEM_OP_LB:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      MEM_OP_LBU: return b;
      MEM_OP_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      MEM_OP_LHU: return h;
      MEM_OP_LW:  return w;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input mem_op_t op, input logic [31:0] addr);
    int sz = op_size(op);
    int unsigned m = ((1 << sz) - 1) << (addr % 4);
    return 4'(m % 16);
  endfunction

  function automatic logic [31:0] ref_wdata(input mem_op_t op, input logic [31:0] d);
    case (op_size(op))
      1:       return (d % 256) * 32'h0101_0101;
      2:       return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Presents one op and completes it: wait_n cycles before ack, frz frozen
  // cycles starting at the ack cycle. Entered and left at posedge+1.
  task automatic run_op(input string nm, input mem_op_t op, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int wait_n, input int frz);
    int sz = op_size(op);
    bit is_mem = (op != MEM_OP_NONE);
    bit mis = is_mem && ((addr % sz) != 0);
    bit go = is_mem && !mis;
    int x0 = xfer_cnt;
    wb_params_t nxt;
    nxt.rd_addr = rd;
    nxt.rd_data = go ? (op_is_store(op) ? 32'd0 : ref_load(op, addr, rdata))
                     : (mis ? 32'd0 : addr);

    mem_params = '{rd_addr: rd, rd_data: addr, mem_op: op, mem_data: data};
    stall_in = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = $urandom;
    #1;
    checks++;
    if (misaligned !== mis) begin
      errors++; $display("FAIL %s misaligned: got %b expected %b", nm, misaligned, mis);
    end
    if (go) begin
      checks++;
      if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata} !==
          {1'b1, op_is_store(op), addr & 32'hFFFF_FFFC, ref_be(op, addr),
           op_is_store(op) ? ref_wdata(op, data) : bus_wdata}) begin
        errors++;
        $display("FAIL %s request: got req=%b we=%b addr=%h be=%b wdata=%h expected we=%b addr=%h be=%b wdata=%h",
                 nm, bus_req, bus_we, bus_addr, bus_be, bus_wdata, op_is_store(op),
                 addr & 32'hFFFF_FFFC, ref_be(op, addr), ref_wdata(op, data));
      end
      for (int i = 0; i < wait_n; i++) begin
        checks++;
        if (mem_stall !== 1'b1 || bus_req !== 1'b1 || wb_params !== exp_wb) begin
          errors++;
          $display("FAIL %s wait%0d: got stall=%b req=%b wb=%h expected stall=1 req=1 wb=%h",
                   nm, i, mem_stall, bus_req, wb_params, exp_wb);
        end
        @(posedge clk); #1;
      end
      bus_ack = 1'b1;
      bus_rdata = rdata;
      stall_in = (frz > 0);
      #1;
      checks++;
      if (mem_stall !== 1'b0) begin
        errors++; $display("FAIL %s ack_stall: got %b expected 0", nm, mem_stall);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      bus_rdata = $urandom;
      if (frz > 0) begin
        for (int i = 1; i < frz; i++) begin
          bus_ack = 1'($urandom_range(0, 1));
          #1;
          checks++;
          if (bus_req !== 1'b0 || mem_stall !== 1'b0 || wb_params !== exp_wb) begin
            errors++;
            $display("FAIL %s freeze%0d: got req=%b stall=%b wb=%h expected req=0 stall=0 wb=%h",
                     nm, i, bus_req, mem_stall, wb_params, exp_wb);
          end
          @(posedge clk); #1;
        end
        bus_ack = 1'b0;
        stall_in = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0) begin
          errors++; $display("FAIL %s release_req: got %b expected 0", nm, bus_req);
        end
        @(posedge clk); #1;
      end
    end else begin
      bus_ack = 1'($urandom_range(0, 1));
      checks++;
      if (bus_req !== 1'b0 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL %s no_req: got req=%b stall=%b expected 0 0", nm, bus_req, mem_stall);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    exp_wb = nxt;
    checks++;
    if (wb_params !== exp_wb) begin
      errors++; $display("FAIL %s wb: got %h expected %h", nm, wb_params, exp_wb);
    end
    checks++;
    if (xfer_cnt - x0 !== int'(go)) begin
      errors++; $display("FAIL %s transfers: got %0d expected %0d", nm, xfer_cnt - x0, int'(go));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall_in = 1'b0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    mem_params = '{rd_addr: 5'd3, rd_data: 32'h100, mem_op: MEM_OP_LW, mem_data: 32'd0};
    repeat (2) @(posedge clk);
    #1;
    exp_wb = '0;
    checks++;
    if (wb_params !== exp_wb || bus_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset: got wb=%h req=%b stall=%b expected wb=0 req=0 stall=0",
               wb_params, bus_req, mem_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_plan();
    run_op("none_pass", MEM_OP_NONE, 5'd5, 32'h1234_5678, 32'd0, 32'd0, 0, 0);
    run_op("lb_103",  MEM_OP_LB,  5'd1, 32'h103, 32'd0, 32'h80FF_0000, 0, 0);
    run_op("lbu_103", MEM_OP_LBU, 5'd2, 32'h103, 32'd0, 32'h80FF_0000, 0, 0);
    run_op("lh_102",  MEM_OP_LH,  5'd3, 32'h102, 32'd0, 32'h80FF_0000, 0, 0);
    run_op("sh_202",  MEM_OP_SH,  5'd0, 32'h202, 32'hAAAA_BEEF, 32'd0, 3, 0);
    run_op("lw_freeze", MEM_OP_LW, 5'd7, 32'h400, 32'd0, 32'hCAFE_F00D, 0, 4);
    run_op("sw_301",  MEM_OP_SW,  5'd0, 32'h301, 32'h1111_2222, 32'd0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_op("b2b", MEM_OP_LW, 5'(i + 8), 32'h800 + 32'(4 * i), 32'd0, $urandom, 0, 0);
  endtask

  task automatic test_reset_mid_wait();
    mem_params = '{rd_addr: 5'd9, rd_data: 32'h500, mem_op: MEM_OP_LW, mem_data: 32'd0};
    stall_in = 1'b0;
    bus_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    exp_wb = '0;
    checks++;
    if (bus_req !== 1'b0 || mem_stall !== 1'b0 || wb_params !== exp_wb) begin
      errors++;
      $display("FAIL rst_mid_wait: got req=%b stall=%b wb=%h expected req=0 stall=0 wb=0",
               bus_req, mem_stall, wb_params);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus_req !== 1'b1) begin
      errors++; $display("FAIL rst_reissue_idle: got req=%b expected 1", bus_req);
    end
    run_op("after_rst", MEM_OP_LW, 5'd9, 32'h500, 32'd0, 32'h0BAD_BEEF, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      mem_op_t op = mem_op_t'($urandom_range(0, 8));
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC | 32'(op_size(op) == 1 ? $urandom_range(0, 3) : 0);
      run_op("rand", op, 5'($urandom_range(0, 31)), addr, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
